// File: rtl/ofmap_writer.sv
// Output-feature-map write-back: packs post/pooled vectors into SRAM words via a small FIFO.
// Optional stall statistics counter enabled by defining OFMAP_WB_STATS_EN.
module ofmap_writer #(
  parameter int POX        = 4,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pool_mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   total_words,
  input  logic [POX*16-1:0]   post_out,
  input  logic                post_out_valid,
  input  logic [POX/2*16-1:0] pooling_out,
  input  logic                pooling_out_valid,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [POX*16-1:0]   wr_data,
  input  logic                wr_ready,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [15:0]         stall_cnt
);

  localparam int DW = POX * 16;
  localparam int HW = DW / 2;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic              pool_q, pool_d;
  logic [ADDR_W-1:0] total_q, total_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [HW-1:0]     half_q, half_d;
  logic              flag_q, flag_d;
  logic              ovf_q, ovf_d;
  logic [DW-1:0]     mem_q [FIFO_DEPTH];

  logic          push;
  logic          mem_we;
  logic          pop;
  logic [DW-1:0] push_data;
  logic          empty;
  logic          full;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  always_comb begin
    state_d   = state_q;
    pool_d    = pool_q;
    total_d   = total_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    half_d    = half_q;
    flag_d    = flag_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    mem_we    = 1'b0;
    pop       = 1'b0;
    push_data = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pool_d  = pool_mode;
          total_d = total_words;
          addr_d  = base_addr;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          half_d  = '0;
          flag_d  = 1'b0;
          wptr_d  = '0;
          rptr_d  = '0;
          state_d = (total_words == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (pool_q) begin
          if (pooling_out_valid) begin
            if (flag_q) begin
              push      = 1'b1;
              push_data = {pooling_out, half_q};
              flag_d    = 1'b0;
            end else begin
              half_d = pooling_out;
              flag_d = 1'b1;
            end
          end
        end else begin
          push      = post_out_valid;
          push_data = post_out;
        end
        pop = !empty && wr_ready;
        if (push) begin
          if (!full || pop) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (pop) begin
          rptr_d = rptr_q + 1'b1;
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (ADDR_W'(cnt_q + 1'b1) == total_q) state_d = DONE;
        end
      end
      DONE: begin
        // Leftover words and any pending half word are discarded here
        wptr_d  = '0;
        rptr_d  = '0;
        half_d  = '0;
        flag_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pool_q  <= 1'b0;
      total_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      half_q  <= '0;
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pool_q  <= pool_d;
      total_q <= total_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      half_q  <= half_d;
      flag_q  <= flag_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[wptr_q[AW-1:0]] <= push_data;
    end
  end

  assign wr_en    = (state_q == RUN) && !empty;
  assign wr_addr  = addr_q;
  assign wr_data  = mem_q[rptr_q[AW-1:0]];
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign overflow = ovf_q;

`ifdef OFMAP_WB_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = '0;
    end else if (wr_en && !wr_ready && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ofmap_writer.sv
// Directed self-checking bench for ofmap_writer (POX=4, ADDR_W=12, FIFO_DEPTH=8).
module tb_ofmap_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        pool_mode;
  logic [11:0] base_addr;
  logic [11:0] total_words;
  logic [63:0] post_out;
  logic        post_out_valid;
  logic [31:0] pooling_out;
  logic        pooling_out_valid;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [63:0] wr_data;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  ofmap_writer #(.POX(4), .ADDR_W(12), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pool_mode(pool_mode),
    .base_addr(base_addr), .total_words(total_words),
    .post_out(post_out), .post_out_valid(post_out_valid),
    .pooling_out(pooling_out), .pooling_out_valid(pooling_out_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .done(done),
    .overflow(overflow), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic pm, input logic [11:0] b,
                          input logic [11:0] t);
    pool_mode   = pm;
    base_addr   = b;
    total_words = t;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  function automatic logic [63:0] pvec(input int i);
    return 64'h1111_2222_3333_0000 + 64'(i * 17);
  endfunction

  task automatic test_reset;
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, done, overflow, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs en=%b addr=%h data=%h busy=%b done=%b ovf=%b stall=%0d want all 0",
               wr_en, wr_addr, wr_data, busy, done, overflow, stall_cnt);
    end
  endtask

  task automatic test_post_mode(input logic [11:0] b);
    logic [11:0] ea;
    wr_ready = 1'b1;
    do_start(1'b0, b, 12'd4);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL post_busy got %b want 1", busy);
    end
    for (int i = 0; i < 4; i++) begin
      post_out       = pvec(i);
      post_out_valid = 1'b1;
      tick();
      ea = b + 12'(i);
      checks++;
      if (wr_en !== 1'b1 || wr_data !== pvec(i) || wr_addr !== ea) begin
        errors++;
        $display("FAIL post_write%0d en=%b data=%h addr=%h want 1 %h %h",
                 i, wr_en, wr_data, wr_addr, pvec(i), ea);
      end
    end
    post_out_valid = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL post_done done=%b busy=%b ovf=%b want 1 0 0",
               done, busy, overflow);
    end
    tick();
    checks++;
    if (done !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL post_done_pulse done=%b en=%b want 0 0", done, wr_en);
    end
  endtask

  task automatic test_pool_mode;
    logic [31:0] pv [4];
    pv[0] = 32'hAAAA_0001;
    pv[1] = 32'hBBBB_0002;
    pv[2] = 32'hCCCC_0003;
    pv[3] = 32'hDDDD_0004;
    wr_ready = 1'b1;
    do_start(1'b1, 12'h000, 12'd2);
    for (int i = 0; i < 4; i++) begin
      pooling_out       = pv[i];
      pooling_out_valid = 1'b1;
      post_out          = 64'hDEAD_BEEF_DEAD_BEEF;
      post_out_valid    = 1'b1;
      tick();
      if (i % 2 == 0) begin
        checks++;
        if (wr_en !== 1'b0) begin
          errors++;
          $display("FAIL pool_half%0d en=%b want 0", i, wr_en);
        end
      end else begin
        checks++;
        if (wr_en !== 1'b1 || wr_data !== {pv[i], pv[i-1]} ||
            wr_addr !== 12'(i / 2)) begin
          errors++;
          $display("FAIL pool_word%0d en=%b data=%h addr=%h want 1 %h %h",
                   i, wr_en, wr_data, wr_addr, {pv[i], pv[i-1]}, i / 2);
        end
      end
    end
    pooling_out_valid = 1'b0;
    post_out_valid    = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL pool_done got %b want 1", done);
    end
    tick();
  endtask

  task automatic test_overflow;
    wr_ready = 1'b0;
    do_start(1'b0, 12'h100, 12'd8);
    for (int i = 0; i < 10; i++) begin
      post_out       = pvec(i + 40);
      post_out_valid = 1'b1;
      tick();
      if (i == 7 || i == 8) begin
        checks++;
        if (overflow !== (i == 8)) begin
          errors++;
          $display("FAIL ovf_after_push%0d got %b want %b", i + 1, overflow, i == 8);
        end
      end
    end
    post_out_valid = 1'b0;
    wr_ready       = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_en !== 1'b1 || wr_data !== pvec(i + 40) ||
          wr_addr !== 12'h100 + 12'(i)) begin
        errors++;
        $display("FAIL ovf_drain%0d en=%b data=%h addr=%h want 1 %h %h",
                 i, wr_en, wr_data, wr_addr, pvec(i + 40), 12'h100 + 12'(i));
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_done done=%b ovf=%b want 1 1", done, overflow);
    end
    tick();
  endtask

  task automatic test_zero_words;
    wr_ready = 1'b1;
    do_start(1'b0, 12'h050, 12'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL zero_done done=%b busy=%b en=%b want 1 0 0",
               done, busy, wr_en);
    end
    tick();
    checks++;
    if (done !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL zero_after done=%b en=%b want 0 0", done, wr_en);
    end
  endtask

  task automatic test_reset_mid;
    wr_ready = 1'b0;
    do_start(1'b0, 12'h200, 12'd4);
    for (int i = 0; i < 2; i++) begin
      post_out       = pvec(i + 80);
      post_out_valid = 1'b1;
      tick();
    end
    post_out_valid = 1'b0;
    checks++;
    if (wr_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre en=%b busy=%b want 1 1", wr_en, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, done, overflow, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL mid_reset en=%b addr=%h data=%h busy=%b done=%b ovf=%b stall=%0d want all 0",
               wr_en, wr_addr, wr_data, busy, done, overflow, stall_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_stall;
    logic [15:0] exp_stall;
`ifdef OFMAP_WB_STATS_EN
    exp_stall = 16'd5;
`else
    exp_stall = 16'd0;
`endif
    wr_ready = 1'b0;
    do_start(1'b0, 12'h300, 12'd1);
    post_out       = pvec(99);
    post_out_valid = 1'b1;
    tick();
    post_out_valid = 1'b0;
    repeat (5) tick();
    checks++;
    if (stall_cnt !== exp_stall || wr_en !== 1'b1) begin
      errors++;
      $display("FAIL stall_cnt got %0d en=%b want %0d 1", stall_cnt, wr_en, exp_stall);
    end
    wr_ready = 1'b1;
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done got %b want 1", done);
    end
    tick();
  endtask

  initial begin
    rst               = 1'b0;
    start             = 1'b0;
    pool_mode         = 1'b0;
    base_addr         = '0;
    total_words       = '0;
    post_out          = '0;
    post_out_valid    = 1'b0;
    pooling_out       = '0;
    pooling_out_valid = 1'b0;
    wr_ready          = 1'b1;
    repeat (2) tick();
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    test_post_mode(12'h010);
    test_pool_mode();
    test_overflow();
    test_post_mode(12'hFFE);
    test_zero_words();
    test_reset_mid();
    test_post_mode(12'h020);
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
